// File: rtl/tlb_entry_pkg.sv
// Shared PTE flag definitions for the TLB entry queue: bit positions of the
// seven permission/fault flags and conversions between the flag struct and its stored vector.
package tlb_entry_pkg;

  localparam int PTE_FLAG_W = 7;

  localparam int FLAG_U        = 0;
  localparam int FLAG_AE_PTW   = 1;
  localparam int FLAG_AE_FINAL = 2;
  localparam int FLAG_PF       = 3;
  localparam int FLAG_GF       = 4;
  localparam int FLAG_SX       = 5;
  localparam int FLAG_PX       = 6;

  typedef logic [PTE_FLAG_W-1:0] pte_flag_vec_t;

  typedef struct packed {
    logic u;
    logic ae_ptw;
    logic ae_final;
    logic pf;
    logic gf;
    logic sx;
    logic px;
  } pte_flags_t;

  function automatic pte_flag_vec_t pack_flags(input pte_flags_t f);
    pte_flag_vec_t v;
    v                = '0;
    v[FLAG_U]        = f.u;
    v[FLAG_AE_PTW]   = f.ae_ptw;
    v[FLAG_AE_FINAL] = f.ae_final;
    v[FLAG_PF]       = f.pf;
    v[FLAG_GF]       = f.gf;
    v[FLAG_SX]       = f.sx;
    v[FLAG_PX]       = f.px;
    return v;
  endfunction

  function automatic pte_flags_t unpack_flags(input pte_flag_vec_t v);
    pte_flags_t f;
    f.u        = v[FLAG_U];
    f.ae_ptw   = v[FLAG_AE_PTW];
    f.ae_final = v[FLAG_AE_FINAL];
    f.pf       = v[FLAG_PF];
    f.gf       = v[FLAG_GF];
    f.sx       = v[FLAG_SX];
    f.px       = v[FLAG_PX];
    return f;
  endfunction

endpackage

// File: rtl/tlb_entry_queue_if.sv
// Handshake bundle around one tlb_entry_queue: enqueue side, dequeue side,
// flush and occupancy. The master is the environment that feeds and drains the queue.
interface tlb_entry_queue_if #(
    parameter int PPN_W = 20,
    parameter int DEPTH = 2
);
    import tlb_entry_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             enq_valid;
    logic [PPN_W-1:0] enq_ppn;
    pte_flags_t       enq_flags;
    logic             deq_ready;
    logic             flush;

    wire              enq_ready;
    wire              deq_valid;
    wire [PPN_W-1:0]  deq_ppn;
    wire pte_flags_t  deq_flags;
    wire [CNT_W-1:0]  count;

    modport master (
        output enq_valid, enq_ppn, enq_flags, deq_ready, flush,
        input  enq_ready, deq_valid, deq_ppn, deq_flags, count
    );

    modport slave (
        input  enq_valid, enq_ppn, enq_flags, deq_ready, flush,
        output enq_ready, deq_valid, deq_ppn, deq_flags, count
    );

endinterface

// File: rtl/tlb_entry_ptr.sv
// Modulo-DEPTH ring pointer with increment enable and synchronous clear;
// clear wins over increment.
module tlb_entry_ptr #(
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [PTR_W-1:0] ptr_o
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] ptr_q, ptr_d;

    // NOTE: combinational blocks use blocking '=' and assign a default first,
    // so every path drives ptr_d and no latch is inferred.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    // NOTE: state registers use non-blocking '<=' so all flops sample
    // their inputs from the same pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/tlb_entry_queue.sv
// Registered elastic buffer for PTW-response PTEs (PPN plus seven flags) feeding
// TLB refill, with optional pipe/flow modes and a synchronous flush.
module tlb_entry_queue
    import tlb_entry_pkg::*;
#(
    parameter  int PPN_W = 20,
    parameter  int DEPTH = 2,
    parameter  bit PIPE  = 1'b0,
    parameter  bit FLOW  = 1'b0,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_enq_valid,
    output logic             io_enq_ready,
    input  logic [PPN_W-1:0] io_enq_bits_ppn,
    input  logic             io_enq_bits_u,
    input  logic             io_enq_bits_ae_ptw,
    input  logic             io_enq_bits_ae_final,
    input  logic             io_enq_bits_pf,
    input  logic             io_enq_bits_gf,
    input  logic             io_enq_bits_sx,
    input  logic             io_enq_bits_px,
    output logic             io_deq_valid,
    input  logic             io_deq_ready,
    output logic [PPN_W-1:0] io_deq_bits_ppn,
    output logic             io_deq_bits_u,
    output logic             io_deq_bits_ae_ptw,
    output logic             io_deq_bits_ae_final,
    output logic             io_deq_bits_pf,
    output logic             io_deq_bits_gf,
    output logic             io_deq_bits_sx,
    output logic             io_deq_bits_px,
    input  logic             io_flush,
    output logic [CNT_W-1:0] io_count
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENTRY_W = PPN_W + PTE_FLAG_W;

    typedef logic [ENTRY_W-1:0] entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic             maybe_full_q, maybe_full_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic       ptr_match, empty, full, flow_sel;
    logic       enq_fire, deq_fire, do_enq, do_deq;
    entry_t     wr_entry, rd_entry;
    pte_flags_t enq_flags, deq_flags;

    assign enq_flags = '{u:        io_enq_bits_u,
                         ae_ptw:   io_enq_bits_ae_ptw,
                         ae_final: io_enq_bits_ae_final,
                         pf:       io_enq_bits_pf,
                         gf:       io_enq_bits_gf,
                         sx:       io_enq_bits_sx,
                         px:       io_enq_bits_px};
    assign wr_entry  = {io_enq_bits_ppn, pack_flags(enq_flags)};

    assign ptr_match = (head == tail);
    assign empty     = ptr_match & ~maybe_full_q;
    assign full      = ptr_match &  maybe_full_q;
    assign flow_sel  = FLOW & empty;

    // Flush masks both handshakes so nothing can transfer in the flush cycle.
    assign io_enq_ready = ~io_flush & (~full  | (PIPE & io_deq_ready));
    assign io_deq_valid = ~io_flush & (~empty | (FLOW & io_enq_valid));

    assign enq_fire = io_enq_valid & io_enq_ready;
    assign deq_fire = io_deq_valid & io_deq_ready;
    // A flow-through transfer bypasses storage entirely.
    assign do_enq   = enq_fire & ~(flow_sel & deq_fire);
    assign do_deq   = deq_fire & ~empty;

    always_comb begin
        maybe_full_d = maybe_full_q;
        count_d      = count_q;
        if (io_flush) begin
            maybe_full_d = 1'b0;
            count_d      = '0;
        end else if (do_enq != do_deq) begin
            maybe_full_d = do_enq;
            count_d      = do_enq ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            maybe_full_q <= 1'b0;
            count_q      <= '0;
        end else begin
            maybe_full_q <= maybe_full_d;
            count_q      <= count_d;
        end
    end

    // NOTE: the payload array has no reset; validity is tracked solely by the
    // pointers and maybe_full, so clearing it would only cost reset fan-out.
    always_ff @(posedge clock) begin
        if (do_enq) begin
            mem_q[tail] <= wr_entry;
        end
    end

    tlb_entry_ptr #(.DEPTH(DEPTH)) u_head_ptr (
        .clock (clock),
        .reset (reset),
        .clr_i (io_flush),
        .inc_i (do_deq),
        .ptr_o (head)
    );

    tlb_entry_ptr #(.DEPTH(DEPTH)) u_tail_ptr (
        .clock (clock),
        .reset (reset),
        .clr_i (io_flush),
        .inc_i (do_enq),
        .ptr_o (tail)
    );

    assign rd_entry        = flow_sel ? wr_entry : mem_q[head];
    assign io_deq_bits_ppn = rd_entry[ENTRY_W-1 -: PPN_W];
    assign deq_flags       = unpack_flags(rd_entry[PTE_FLAG_W-1:0]);

    assign io_deq_bits_u        = deq_flags.u;
    assign io_deq_bits_ae_ptw   = deq_flags.ae_ptw;
    assign io_deq_bits_ae_final = deq_flags.ae_final;
    assign io_deq_bits_pf       = deq_flags.pf;
    assign io_deq_bits_gf       = deq_flags.gf;
    assign io_deq_bits_sx       = deq_flags.sx;
    assign io_deq_bits_px       = deq_flags.px;
    assign io_count             = count_q;

endmodule

// File: tb/tb_tlb_entry_queue.sv
// Scoreboard bench for tlb_entry_queue: instance A (DEPTH=2, PIPE) covers order,
// pipe, flush and async reset; instance B (DEPTH=3, FLOW) covers flow-through and wrap.
module tb_tlb_entry_queue;
    import tlb_entry_pkg::*;

    localparam int PPN_W = 20;
    typedef logic [PPN_W+PTE_FLAG_W-1:0] ent_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int total = 0;
    int bad   = 0;
    int a_enq_n = 0, a_deq_n = 0, b_enq_n = 0, b_deq_n = 0;
    ent_t qa[$];
    ent_t qb[$];

    tlb_entry_queue_if #(.PPN_W(PPN_W), .DEPTH(2)) a_if ();
    tlb_entry_queue_if #(.PPN_W(PPN_W), .DEPTH(3)) b_if ();

    always #5 clock = ~clock;

    tlb_entry_queue #(.PPN_W(PPN_W), .DEPTH(2), .PIPE(1'b1), .FLOW(1'b0)) u_dut_a (
        .clock(clock), .reset(reset),
        .io_enq_valid(a_if.enq_valid), .io_enq_ready(a_if.enq_ready),
        .io_enq_bits_ppn(a_if.enq_ppn),
        .io_enq_bits_u(a_if.enq_flags.u), .io_enq_bits_ae_ptw(a_if.enq_flags.ae_ptw),
        .io_enq_bits_ae_final(a_if.enq_flags.ae_final), .io_enq_bits_pf(a_if.enq_flags.pf),
        .io_enq_bits_gf(a_if.enq_flags.gf), .io_enq_bits_sx(a_if.enq_flags.sx),
        .io_enq_bits_px(a_if.enq_flags.px),
        .io_deq_valid(a_if.deq_valid), .io_deq_ready(a_if.deq_ready),
        .io_deq_bits_ppn(a_if.deq_ppn),
        .io_deq_bits_u(a_if.deq_flags.u), .io_deq_bits_ae_ptw(a_if.deq_flags.ae_ptw),
        .io_deq_bits_ae_final(a_if.deq_flags.ae_final), .io_deq_bits_pf(a_if.deq_flags.pf),
        .io_deq_bits_gf(a_if.deq_flags.gf), .io_deq_bits_sx(a_if.deq_flags.sx),
        .io_deq_bits_px(a_if.deq_flags.px),
        .io_flush(a_if.flush), .io_count(a_if.count)
    );

    tlb_entry_queue #(.PPN_W(PPN_W), .DEPTH(3), .PIPE(1'b0), .FLOW(1'b1)) u_dut_b (
        .clock(clock), .reset(reset),
        .io_enq_valid(b_if.enq_valid), .io_enq_ready(b_if.enq_ready),
        .io_enq_bits_ppn(b_if.enq_ppn),
        .io_enq_bits_u(b_if.enq_flags.u), .io_enq_bits_ae_ptw(b_if.enq_flags.ae_ptw),
        .io_enq_bits_ae_final(b_if.enq_flags.ae_final), .io_enq_bits_pf(b_if.enq_flags.pf),
        .io_enq_bits_gf(b_if.enq_flags.gf), .io_enq_bits_sx(b_if.enq_flags.sx),
        .io_enq_bits_px(b_if.enq_flags.px),
        .io_deq_valid(b_if.deq_valid), .io_deq_ready(b_if.deq_ready),
        .io_deq_bits_ppn(b_if.deq_ppn),
        .io_deq_bits_u(b_if.deq_flags.u), .io_deq_bits_ae_ptw(b_if.deq_flags.ae_ptw),
        .io_deq_bits_ae_final(b_if.deq_flags.ae_final), .io_deq_bits_pf(b_if.deq_flags.pf),
        .io_deq_bits_gf(b_if.deq_flags.gf), .io_deq_bits_sx(b_if.deq_flags.sx),
        .io_deq_bits_px(b_if.deq_flags.px),
        .io_flush(b_if.flush), .io_count(b_if.count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic pte_flags_t fl(input bit u, ae_ptw, ae_final, pf, gf, sx, px);
        pte_flags_t f;
        f = '{u: u, ae_ptw: ae_ptw, ae_final: ae_final, pf: pf, gf: gf, sx: sx, px: px};
        return f;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic a_drive(input logic v, input logic [PPN_W-1:0] ppn, input pte_flags_t f,
                           input logic dr);
        a_if.enq_valid = v;
        a_if.enq_ppn   = ppn;
        a_if.enq_flags = f;
        a_if.deq_ready = dr;
    endtask

    task automatic b_drive(input logic v, input logic [PPN_W-1:0] ppn, input pte_flags_t f,
                           input logic dr);
        b_if.enq_valid = v;
        b_if.enq_ppn   = ppn;
        b_if.enq_flags = f;
        b_if.deq_ready = dr;
    endtask

    // Monitor A: DEPTH=2, PIPE=1, FLOW=0. Pop before push (no flow-through).
    always @(negedge clock) begin
        if (reset) begin
            qa.delete();
            check("a_rst_count", a_if.count, 0);
            check("a_rst_deq_valid", a_if.deq_valid, 0);
            check("a_rst_enq_ready", a_if.enq_ready, 1);
        end else begin
            check("a_count", a_if.count, qa.size());
            check("a_enq_ready", a_if.enq_ready,
                  !a_if.flush && (qa.size() < 2 || a_if.deq_ready));
            check("a_deq_valid", a_if.deq_valid, !a_if.flush && qa.size() > 0);
            if (a_if.flush) begin
                qa.delete();
            end else begin
                if (a_if.deq_valid && a_if.deq_ready) begin
                    a_deq_n++;
                    if (qa.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL a_deq_unexpected: got=%0h expected=none", a_if.deq_ppn);
                    end else begin
                        check("a_deq_data", {a_if.deq_ppn, a_if.deq_flags}, qa.pop_front());
                    end
                end
                if (a_if.enq_valid && a_if.enq_ready) begin
                    a_enq_n++;
                    qa.push_back({a_if.enq_ppn, a_if.enq_flags});
                end
            end
        end
    end

    // Monitor B: DEPTH=3, PIPE=0, FLOW=1. Push before pop so flow-through matches.
    always @(negedge clock) begin
        if (reset) begin
            qb.delete();
            check("b_rst_count", b_if.count, 0);
            check("b_rst_deq_valid", b_if.deq_valid, 0);
            check("b_rst_enq_ready", b_if.enq_ready, 1);
        end else begin
            check("b_count", b_if.count, qb.size());
            check("b_count_max", b_if.count <= 3, 1);
            check("b_enq_ready", b_if.enq_ready, !b_if.flush && qb.size() < 3);
            check("b_deq_valid", b_if.deq_valid,
                  !b_if.flush && (qb.size() > 0 || b_if.enq_valid));
            if (b_if.flush) begin
                qb.delete();
            end else begin
                if (b_if.enq_valid && b_if.enq_ready) begin
                    b_enq_n++;
                    qb.push_back({b_if.enq_ppn, b_if.enq_flags});
                end
                if (b_if.deq_valid && b_if.deq_ready) begin
                    b_deq_n++;
                    if (qb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL b_deq_unexpected: got=%0h expected=none", b_if.deq_ppn);
                    end else begin
                        check("b_deq_data", {b_if.deq_ppn, b_if.deq_flags}, qb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int e0, d0, sent, r0;
        logic [31:0] enq_pat, deq_pat;

        a_drive(0, '0, '0, 0);
        b_drive(0, '0, '0, 0);
        a_if.flush = 1'b0;
        b_if.flush = 1'b0;

        // Reset values while reset is held, then release.
        tick();
        #2;
        check("rst_a_count", a_if.count, 0);
        check("rst_a_deq_valid", a_if.deq_valid, 0);
        check("rst_a_enq_ready", a_if.enq_ready, 1);
        tick();
        tick();
        reset = 1'b0;

        // Basic order: two entries, full, drain in order.
        tick();
        a_drive(1, 20'h00001, fl(0, 0, 0, 1, 0, 0, 0), 0);
        tick();
        a_drive(1, 20'h00002, fl(0, 0, 0, 0, 0, 1, 0), 0);
        tick();
        a_drive(0, '0, '0, 0);
        #2;
        check("basic_full_count", a_if.count, 2);
        check("basic_full_enq_ready", a_if.enq_ready, 0);
        tick();
        a_drive(0, '0, '0, 1);
        #2;
        check("basic_deq0_ppn", a_if.deq_ppn, 20'h00001);
        check("basic_deq0_flags", a_if.deq_flags, fl(0, 0, 0, 1, 0, 0, 0));
        tick();
        #2;
        check("basic_deq1_ppn", a_if.deq_ppn, 20'h00002);
        check("basic_deq1_flags", a_if.deq_flags, fl(0, 0, 0, 0, 0, 1, 0));
        tick();
        a_drive(0, '0, '0, 0);
        #2;
        check("basic_empty_count", a_if.count, 0);

        // PIPE: full queue sustains one transfer per cycle on both sides.
        tick();
        a_drive(1, 20'h00100, fl(1, 0, 0, 0, 0, 0, 0), 0);
        tick();
        a_drive(1, 20'h00101, fl(0, 1, 0, 0, 0, 0, 0), 0);
        tick();
        e0 = a_enq_n;
        d0 = a_deq_n;
        for (int i = 0; i < 10; i++) begin
            a_drive(1, PPN_W'(32'h200 + i), pte_flags_t'(7'(i * 13 + 5)), 1);
            #2;
            check("pipe_enq_ready", a_if.enq_ready, 1);
            check("pipe_count", a_if.count, 2);
            tick();
        end
        check("pipe_enq_transfers", a_enq_n - e0, 10);
        check("pipe_deq_transfers", a_deq_n - d0, 10);
        a_drive(0, '0, '0, 1);
        tick();
        tick();
        a_drive(0, '0, '0, 0);
        #2;
        check("pipe_drained_count", a_if.count, 0);

        // Flush with an entry offered in the same cycle.
        tick();
        a_drive(1, 20'h00300, fl(0, 0, 1, 0, 0, 0, 0), 0);
        tick();
        a_drive(1, 20'h00301, fl(0, 0, 0, 0, 1, 0, 0), 0);
        tick();
        a_drive(1, 20'hDEAD0, fl(1, 1, 1, 1, 1, 1, 1), 0);
        a_if.flush = 1'b1;
        #2;
        check("flush_enq_ready", a_if.enq_ready, 0);
        check("flush_deq_valid", a_if.deq_valid, 0);
        tick();
        a_if.flush = 1'b0;
        a_drive(0, '0, '0, 0);
        #2;
        check("post_flush_count", a_if.count, 0);
        check("post_flush_deq_valid", a_if.deq_valid, 0);
        check("post_flush_enq_ready", a_if.enq_ready, 1);
        tick();
        a_drive(1, 20'h00400, fl(0, 0, 0, 0, 0, 0, 1), 0);
        tick();
        a_drive(0, '0, '0, 1);
        #2;
        check("post_flush_first_ppn", a_if.deq_ppn, 20'h00400);
        tick();
        a_drive(0, '0, '0, 0);

        // Async reset between clock edges with two entries held.
        tick();
        a_drive(1, 20'h00500, fl(0, 0, 0, 1, 1, 0, 0), 0);
        tick();
        a_drive(1, 20'h00501, fl(0, 0, 1, 1, 0, 0, 0), 0);
        tick();
        a_drive(0, '0, '0, 0);
        #2;
        check("pre_reset_count", a_if.count, 2);
        reset = 1'b1;
        #1;
        check("async_rst_count", a_if.count, 0);
        check("async_rst_deq_valid", a_if.deq_valid, 0);
        check("async_rst_enq_ready", a_if.enq_ready, 1);
        tick();
        tick();
        reset = 1'b0;
        a_drive(1, 20'h00600, fl(0, 1, 0, 0, 0, 1, 0), 0);
        tick();
        a_drive(1, 20'h00601, fl(1, 0, 0, 0, 0, 0, 1), 0);
        tick();
        a_drive(0, '0, '0, 1);
        #2;
        check("post_reset_first_ppn", a_if.deq_ppn, 20'h00600);
        tick();
        #2;
        check("post_reset_second_ppn", a_if.deq_ppn, 20'h00601);
        tick();
        a_drive(0, '0, '0, 0);

        // FLOW: empty queue passes the entry through in the same cycle.
        tick();
        b_drive(1, 20'hABCDE, fl(1, 0, 0, 0, 0, 0, 1), 1);
        #2;
        check("flow_deq_valid", b_if.deq_valid, 1);
        check("flow_deq_ppn", b_if.deq_ppn, 20'hABCDE);
        check("flow_deq_flags", b_if.deq_flags, fl(1, 0, 0, 0, 0, 0, 1));
        check("flow_count", b_if.count, 0);
        tick();
        b_drive(0, '0, '0, 0);
        #2;
        check("flow_after_count", b_if.count, 0);
        check("flow_after_deq_valid", b_if.deq_valid, 0);

        // Wrap-around on DEPTH=3: 7 entries with fixed stall patterns.
        enq_pat = 32'hF3B7_6DEF;
        deq_pat = 32'hA5B6_DBE0;
        sent = 0;
        r0 = b_deq_n;
        tick();
        for (int cyc = 0; cyc < 200 && (b_deq_n - r0) < 7; cyc++) begin
            b_drive((sent < 7) && enq_pat[cyc % 32], PPN_W'(32'h700 + sent),
                    pte_flags_t'(7'(sent * 19 + 3)), deq_pat[cyc % 32]);
            #2;
            if (b_if.enq_valid && b_if.enq_ready) sent++;
            tick();
        end
        b_drive(0, '0, '0, 0);
        check("wrap_received", b_deq_n - r0, 7);
        check("wrap_sent", sent, 7);

        tick();
        check("a_scoreboard_empty", qa.size(), 0);
        check("b_scoreboard_empty", qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
